// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//
// Serialises a word-wide configuration bitstream (MSB of each word first)
// onto the configuration-chain head of the io logical tiles. Bits are only
// valid while ccff_shift_en is high, which also gates the fabric programming
// clock. Pad isolation (IO_ISOL_N low) is held until the whole chain has been
// loaded; a starved host ends the load in a sticky error state instead.
//
// Ports:
//   prog_clk       programming clock, all state on the rising edge
//   prog_reset_n   asynchronous active-low reset
//   start          one-cycle pulse, begins a (re)load from IDLE/DONE/ERR
//   word_valid     host has a word on word_data
//   word_data      bitstream word, MSB shifted first
//   word_ready     loader accepts word_data this cycle
//   ccff_head      serial bit into the configuration chain
//   ccff_shift_en  high exactly on cycles where ccff_head carries a valid bit
//   ccff_tail      chain tail, captured into tail_bit_q at end of load
//   IO_ISOL_N      pad isolation release (0 = isolated)
//   busy           load in progress
//   done           load completed (sticky until next start/reset)
//   error          starvation timeout (sticky until next start/reset)
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 1024,
  parameter int CNT_WIDTH    = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  start,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic                  IO_ISOL_N,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int WBIT_W   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int STARVE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  // Elaboration-time parameter checks: the bit counter must never wrap.
  if (longint'(CHAIN_LENGTH) >= (64'd1 << CNT_WIDTH)) begin : g_bad_cnt_width
    $error("ccff_bitstream_loader: CHAIN_LENGTH must be < 2**CNT_WIDTH");
  end
  if (CHAIN_LENGTH < 1) begin : g_bad_chain_length
    $error("ccff_bitstream_loader: CHAIN_LENGTH must be >= 1");
  end
  if (WORD_WIDTH < 1 || WORD_WIDTH > 64) begin : g_bad_word_width
    $error("ccff_bitstream_loader: WORD_WIDTH must be in 1..64");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("ccff_bitstream_loader: TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_FINISH,
    S_DONE,
    S_ERR
  } state_e;

  state_e                state_q,    state_d;
  logic [WORD_WIDTH-1:0] shreg_q,    shreg_d;     // bits still to emit, MSB next
  logic                  head_q,     head_d;      // bit currently on ccff_head
  logic [CNT_WIDTH-1:0]  bit_cnt_q,  bit_cnt_d;   // chain bits emitted so far
  logic [WBIT_W-1:0]     wbit_q,     wbit_d;      // position inside current word
  logic [STARVE_W-1:0]   starve_q,   starve_d;    // consecutive starved FETCH cycles
  logic                  tail_bit_q, tail_bit_d;
  logic                  shift_en_q, shift_en_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  error_q,    error_d;
  logic                  isol_n_q,   isol_n_d;

  logic last_word_bit;
  logic last_chain_bit;
  logic accept;

  assign last_word_bit  = (wbit_q == WBIT_W'(WORD_WIDTH - 1));
  assign last_chain_bit = (bit_cnt_q == CNT_WIDTH'(CHAIN_LENGTH - 1));

  // The next word is requested during the last bit of the current one so
  // back-to-back words stream without a bubble; no request follows the
  // final chain bit.
  assign word_ready = (state_q == S_FETCH) ||
                      ((state_q == S_SHIFT) && last_word_bit && !last_chain_bit);
  assign accept     = word_valid && word_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    shreg_d    = shreg_q;
    head_d     = head_q;
    bit_cnt_d  = bit_cnt_q;
    wbit_d     = wbit_q;
    starve_d   = starve_q;
    tail_bit_d = tail_bit_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_FETCH;
          bit_cnt_d = '0;
          wbit_d    = '0;
          starve_d  = '0;
        end
      end

      S_FETCH: begin
        if (!word_valid) begin
          if (starve_q == STARVE_W'(TIMEOUT - 1)) begin
            state_d = S_ERR;
          end else begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end
      end

      S_SHIFT: begin
        bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
        wbit_d    = last_word_bit ? '0 : wbit_q + WBIT_W'(1);
        if (last_chain_bit) begin
          // Any unsent bits of a partial final word are simply dropped.
          state_d = S_FINISH;
        end else if (last_word_bit) begin
          if (!word_valid) begin
            state_d  = S_FETCH;
            starve_d = '0;
          end
        end else begin
          head_d  = shreg_q[WORD_WIDTH-1];
          shreg_d = shreg_q << 1;
        end
      end

      S_FINISH: begin
        tail_bit_d = ccff_tail;
        state_d    = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

    // A handshake always loads the word and (re)starts shifting next cycle;
    // the MSB goes straight to the head register.
    if (accept) begin
      state_d  = S_SHIFT;
      head_d   = word_data[WORD_WIDTH-1];
      shreg_d  = word_data << 1;
      starve_d = '0;
    end
  end

  // Outputs are registered from the next state so they change cleanly with
  // the state they describe.
  always_comb begin
    shift_en_d = (state_d == S_SHIFT);
    busy_d     = (state_d == S_FETCH) || (state_d == S_SHIFT) || (state_d == S_FINISH);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    isol_n_d   = (state_d == S_DONE);
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      head_q     <= 1'b0;
      bit_cnt_q  <= '0;
      wbit_q     <= '0;
      starve_q   <= '0;
      tail_bit_q <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      isol_n_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      head_q     <= head_d;
      bit_cnt_q  <= bit_cnt_d;
      wbit_q     <= wbit_d;
      starve_q   <= starve_d;
      tail_bit_q <= tail_bit_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      isol_n_q   <= isol_n_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign IO_ISOL_N     = isol_n_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// Bench for ccff_bitstream_loader. Two instances share clock and reset:
//   u_dut0: WORD_WIDTH=8, CHAIN_LENGTH=16, TIMEOUT=8 (gaps up to 5 cycles)
//   u_dut1: WORD_WIDTH=8, CHAIN_LENGTH=12, TIMEOUT=4 (truncation, timeout)
// Each instance drives a behavioural chain model whose tail loops back to
// ccff_tail. Expected streams are built from the offered words by plain
// bit slicing; inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ccff_bitstream_loader;

  localparam int WW  = 8;
  localparam int CL0 = 16;
  localparam int CL1 = 12;
  localparam int TO0 = 8;
  localparam int TO1 = 4;

  logic prog_clk = 1'b0;
  logic prog_reset_n;
  always #5 prog_clk = ~prog_clk;

  logic          start_s [2];
  logic          valid_s [2];
  logic [WW-1:0] data_s  [2];
  logic          ready_s [2];
  logic          head_s  [2];
  logic          sen_s   [2];
  logic          tail_s  [2];
  logic          isol_s  [2];
  logic          busy_s  [2];
  logic          done_s  [2];
  logic          err_s   [2];
  logic [15:0]   chain_m [2];

  assign tail_s[0] = chain_m[0][CL0-1];
  assign tail_s[1] = chain_m[1][CL1-1];

  ccff_bitstream_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL0), .CNT_WIDTH(5), .TIMEOUT(TO0)) u_dut0 (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_s[0]),
    .word_valid(valid_s[0]), .word_data(data_s[0]), .word_ready(ready_s[0]),
    .ccff_head(head_s[0]), .ccff_shift_en(sen_s[0]), .ccff_tail(tail_s[0]),
    .IO_ISOL_N(isol_s[0]), .busy(busy_s[0]), .done(done_s[0]), .error(err_s[0])
  );

  ccff_bitstream_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL1), .CNT_WIDTH(5), .TIMEOUT(TO1)) u_dut1 (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_s[1]),
    .word_valid(valid_s[1]), .word_data(data_s[1]), .word_ready(ready_s[1]),
    .ccff_head(head_s[1]), .ccff_shift_en(sen_s[1]), .ccff_tail(tail_s[1]),
    .IO_ISOL_N(isol_s[1]), .busy(busy_s[1]), .done(done_s[1]), .error(err_s[1])
  );

  int tests = 0;
  int fails = 0;

  logic [WW-1:0] words_q[$];
  int            gaps_q[$];

  // Runs one complete load on instance d using words_q / gaps_q. gaps_q[i]
  // is the number of word_ready cycles the host refuses before offering
  // word i. words_q holds one word more than the chain needs.
  task automatic run_load(input int d, input string tag);
    int cl, exp_hs, exp_low, exp_ready, handshakes, ready_cycles;
    int cyc, first_bit, last_bit, done_cyc, gap, mism, low;
    bit finished;
    bit exp_bits[$];
    bit got_bits[$];
    logic [WW-1:0] wq[$];
    int gq[$];
    logic [15:0] exp_chain;
    logic tail_dut;

    cl = (d == 0) ? CL0 : CL1;
    exp_hs = (cl + WW - 1) / WW;
    for (int i = 0; i < exp_hs; i++)
      for (int b = WW - 1; b >= 0; b--)
        if (exp_bits.size() < cl) exp_bits.push_back(words_q[i][b]);
    exp_low = 0;
    exp_ready = exp_hs;
    for (int i = 0; i < exp_hs; i++) begin
      exp_ready += gaps_q[i];
      if (i > 0) exp_low += gaps_q[i];
    end
    exp_chain = '0;
    foreach (exp_bits[i]) exp_chain = {exp_chain[14:0], exp_bits[i]};

    chain_m[d] = '0;
    @(negedge prog_clk);
    start_s[d] = 1'b1;
    valid_s[d] = 1'b0;
    @(negedge prog_clk);
    start_s[d] = 1'b0;

    tests++;
    if ({busy_s[d], done_s[d], err_s[d], isol_s[d]} !== 4'b1000) begin
      fails++;
      $display("FAIL %s start_status: busy/done/err/isol=%b expected 1000", tag,
               {busy_s[d], done_s[d], err_s[d], isol_s[d]});
    end

    wq = words_q;
    gq = gaps_q;
    gap = gq.pop_front();
    handshakes = 0; ready_cycles = 0; cyc = 0;
    first_bit = -1; last_bit = -1; done_cyc = -1; finished = 0;
    while (!finished && cyc < 400) begin
      if (sen_s[d]) begin
        got_bits.push_back(head_s[d]);
        if (first_bit < 0) first_bit = cyc;
        last_bit = cyc;
        chain_m[d] = {chain_m[d][14:0], head_s[d]};
      end
      if (done_s[d] || err_s[d]) begin
        done_cyc = done_s[d] ? cyc : -1;
        finished = 1;
        valid_s[d] = 1'b0;
      end else begin
        if (ready_s[d]) ready_cycles++;
        if (ready_s[d] && gap > 0) begin
          gap--;
          valid_s[d] = 1'b0;
        end else if (wq.size() > 0) begin
          valid_s[d] = 1'b1;
          data_s[d]  = wq[0];
        end else begin
          valid_s[d] = 1'b0;
        end
        if (valid_s[d] && ready_s[d]) begin
          handshakes++;
          void'(wq.pop_front());
          gap = (gq.size() > 0) ? gq.pop_front() : 0;
        end
        @(negedge prog_clk);
        cyc++;
      end
    end

    tests++;
    if (done_cyc < 0) begin
      fails++;
      $display("FAIL %s completion: done not seen within %0d cycles (error=%b)", tag, cyc, err_s[d]);
    end

    mism = (got_bits.size() == exp_bits.size()) ? 0 : 1;
    for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++)
      if (got_bits[i] !== exp_bits[i]) mism++;
    tests++;
    if (mism != 0) begin
      fails++;
      $display("FAIL %s bitstream: got %0d bits (%0d wrong) expected %0d bits", tag,
               got_bits.size(), mism, exp_bits.size());
    end

    low = (first_bit < 0) ? -1 : (last_bit - first_bit + 1) - got_bits.size();
    tests++;
    if (low != exp_low) begin
      fails++;
      $display("FAIL %s shift_gaps: idle cycles inside stream %0d expected %0d", tag, low, exp_low);
    end

    tests++;
    if (done_cyc - last_bit != 2) begin
      fails++;
      $display("FAIL %s done_latency: %0d cycles after last bit expected 2", tag, done_cyc - last_bit);
    end

    tests++;
    if (handshakes != exp_hs || ready_cycles != exp_ready) begin
      fails++;
      $display("FAIL %s handshakes: accepted %0d ready_cycles %0d expected %0d and %0d", tag,
               handshakes, ready_cycles, exp_hs, exp_ready);
    end

    mism = 0;
    for (int i = 0; i < cl; i++)
      if (chain_m[d][cl-1-i] !== exp_bits[i]) mism++;
    tests++;
    if (mism != 0) begin
      fails++;
      $display("FAIL %s chain_contents: chain %h expected %h", tag, chain_m[d], exp_chain);
    end

    tail_dut = (d == 0) ? u_dut0.tail_bit_q : u_dut1.tail_bit_q;
    tests++;
    if (tail_dut !== exp_bits[0]) begin
      fails++;
      $display("FAIL %s tail_bit: got %b expected %b", tag, tail_dut, exp_bits[0]);
    end

    @(negedge prog_clk);
    tests++;
    if ({busy_s[d], done_s[d], err_s[d], isol_s[d], ready_s[d], sen_s[d]} !== 6'b010100) begin
      fails++;
      $display("FAIL %s done_status: busy/done/err/isol/ready/sen=%b expected 010100", tag,
               {busy_s[d], done_s[d], err_s[d], isol_s[d], ready_s[d], sen_s[d]});
    end
  endtask

  task automatic test_reset();
    prog_reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; valid_s[d] = 1'b0; data_s[d] = '0; chain_m[d] = '0;
    end
    repeat (3) @(negedge prog_clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if ({ready_s[d], head_s[d], sen_s[d], isol_s[d], busy_s[d], done_s[d], err_s[d]} !== 7'b0) begin
        fails++;
        $display("FAIL reset_state dut%0d: outputs %b expected 0000000", d,
                 {ready_s[d], head_s[d], sen_s[d], isol_s[d], busy_s[d], done_s[d], err_s[d]});
      end
    end
    prog_reset_n = 1'b1;
    // word_valid while idle must not be taken
    valid_s[0] = 1'b1; data_s[0] = 8'hFF;
    @(negedge prog_clk);
    tests++;
    if ({ready_s[0], busy_s[0], sen_s[0]} !== 3'b000) begin
      fails++;
      $display("FAIL idle_valid_ignored: ready/busy/sen=%b expected 000", {ready_s[0], busy_s[0], sen_s[0]});
    end
    valid_s[0] = 1'b0;
  endtask

  task automatic test_stream_a5_3c();
    words_q = '{8'hA5, 8'h3C, 8'($urandom)};
    gaps_q  = '{0, 0, 0};
    run_load(0, "stream_a5_3c");
  endtask

  task automatic test_truncate();
    words_q = '{8'hFF, 8'hF0, 8'($urandom)};
    gaps_q  = '{0, 0, 0};
    run_load(1, "truncate_12");
  endtask

  task automatic test_host_gap();
    words_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    gaps_q  = '{0, 5, 0};
    run_load(0, "host_gap_5");
  endtask

  task automatic test_timeout();
    int first_err;
    @(negedge prog_clk);
    start_s[1] = 1'b1;
    valid_s[1] = 1'b0;
    @(negedge prog_clk);
    start_s[1] = 1'b0;
    first_err = -1;
    for (int c = 1; c <= 8; c++) begin
      if (err_s[1] === 1'b1 && first_err < 0) first_err = c;
      if (first_err < 0) @(negedge prog_clk);
    end
    tests++;
    if (first_err != TO1 + 1) begin
      fails++;
      $display("FAIL timeout_cycle: error on FETCH cycle %0d expected %0d", first_err, TO1 + 1);
    end
    tests++;
    if ({err_s[1], isol_s[1], busy_s[1], sen_s[1], ready_s[1], done_s[1]} !== 6'b100000) begin
      fails++;
      $display("FAIL timeout_status: err/isol/busy/sen/ready/done=%b expected 100000",
               {err_s[1], isol_s[1], busy_s[1], sen_s[1], ready_s[1], done_s[1]});
    end
    // A fresh start from ERR must clear error and load normally.
    words_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    gaps_q  = '{1, 2, 0};
    run_load(1, "reload_after_error");
  endtask

  task automatic test_reset_mid_shift();
    int nbits;
    bit hit;
    @(negedge prog_clk);
    start_s[0] = 1'b1;
    valid_s[0] = 1'b0;
    @(negedge prog_clk);
    start_s[0] = 1'b0;
    nbits = 0;
    hit = 0;
    for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
      if (sen_s[0]) begin
        if (nbits == 7) begin
          hit = 1;
          #1 prog_reset_n = 1'b0;
          #1;
          tests++;
          if ({ready_s[0], head_s[0], sen_s[0], isol_s[0], busy_s[0], done_s[0], err_s[0]} !== 7'b0) begin
            fails++;
            $display("FAIL reset_async_mid_shift: outputs %b expected 0000000",
                     {ready_s[0], head_s[0], sen_s[0], isol_s[0], busy_s[0], done_s[0], err_s[0]});
          end
        end
        nbits++;
      end
      if (!hit) begin
        valid_s[0] = 1'b1;
        data_s[0]  = 8'($urandom);
        @(negedge prog_clk);
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL reset_mid_shift_reach: saw %0d bits expected to reach bit 7", nbits);
    end
    valid_s[0] = 1'b0;
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    words_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    gaps_q  = '{0, 0, 0};
    run_load(0, "load_after_reset");
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 8; i++) begin
      int d;
      d = i % 2;
      words_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
      gaps_q  = '{$urandom_range(0, 3), $urandom_range(0, (d == 0) ? 5 : 2), 0};
      run_load(d, $sformatf("random_%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_stream_a5_3c();
    test_truncate();
    test_host_gap();
    test_timeout();
    test_reset_mid_shift();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Serialises a word-wide configuration bitstream onto the configuration-chain head (ccff_head) of the io logical tiles and the tiles chained after them.
- Gates fabric programming-clock shifting through ccff_shift_en.
- Holds pad isolation (IO_ISOL_N low) until the chain is fully loaded.
- Sits directly upstream of the io tile's ccff_head / IO_ISOL_N inputs; it is driven by the SoC-side config host.

Parameters:
- WORD_WIDTH, 32, bitstream word width (1..64)
- CHAIN_LENGTH, 1024, total configuration bits in the chain (>= 1)
- CNT_WIDTH, 16, width of the bit counter; must satisfy 2^CNT_WIDTH > CHAIN_LENGTH
- TIMEOUT, 255, maximum consecutive starved cycles in LOAD before error

Ports:
- prog_clk  input  1  programming clock; all state on rising edge
- prog_reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begin a load
- word_valid  input  1  host word available
- word_data  input  WORD_WIDTH  bitstream word, MSB shifted first
- word_ready  output  1  loader accepts word_data this cycle
- ccff_head  output  1  serial bit into configuration chain
- ccff_shift_en  output  1  high exactly on cycles where ccff_head carries a valid bit; gates fabric prog_clk
- ccff_tail  input  1  chain tail, sampled for the end-of-load check
- IO_ISOL_N  output  1  pad isolation release (0 = isolated)
- busy  output  1  load in progress
- done  output  1  load completed successfully (sticky until next start/reset)
- error  output  1  starvation timeout (sticky until next start/reset)

Behaviour:
- Reset (async assert, sync-released use): state IDLE; ccff_head=0, ccff_shift_en=0, word_ready=0, IO_ISOL_N=0, busy=0, done=0, error=0; counters cleared. Asserting reset mid-load aborts immediately; IO_ISOL_N returns to 0.
- States: IDLE, FETCH, SHIFT, FINISH, DONE, ERR.
- IDLE: start=1 -> FETCH next cycle; busy=1, done=0, error=0, IO_ISOL_N=0, bit counter=0. start is ignored outside IDLE/DONE/ERR. start in DONE or ERR behaves as in IDLE (reload).
- FETCH: word_ready=1. On word_valid&&word_ready, load the shift register and go to SHIFT; starve counter=0. Without word_valid, starve counter increments; reaching TIMEOUT -> ERR.
- SHIFT: each cycle ccff_head = shreg MSB, ccff_shift_en=1, shreg <<= 1, bit counter += 1.
  - Word boundaries are gapless: on the last bit of a word, word_ready=1 in the same cycle. If word_valid, the next word loads and shifting continues next cycle; otherwise go to FETCH with ccff_shift_en=0.
  - When the bit counter reaches CHAIN_LENGTH, go to FINISH. Remaining bits of a partial final word are discarded. No word_ready is raised after the final bit.
- Throughput: one bit per cycle when the host keeps word_valid high. First ccff_shift_en occurs 1 cycle after the accepting handshake.
- FINISH: one cycle; ccff_shift_en=0; ccff_tail is sampled into status register tail_bit (internal, observable by the bench). Then go to DONE.
- DONE: busy=0, done=1, IO_ISOL_N=1 from the first DONE cycle.
- ERR: busy=0, error=1, IO_ISOL_N stays 0, ccff_shift_en=0. The chain contents are undefined.
- ccff_head holds its last value when ccff_shift_en=0. The fabric must not depend on it then.
- Simultaneous events:
  - start and reset: reset wins.
  - word_valid in IDLE: ignored, word_ready=0.
  - Counter must not wrap: CHAIN_LENGTH < 2^CNT_WIDTH is enforced by an elaboration check.

Test Plan:
- WORD_WIDTH=8, CHAIN_LENGTH=16. Pulse start, words 0xA5, 0x3C, word_valid held high -> ccff_head sequence 1010010100111100 on 16 consecutive ccff_shift_en cycles; done=1 and IO_ISOL_N=1 2 cycles after the last bit (FINISH, then DONE).
- Same config with CHAIN_LENGTH=12. Words 0xFF, 0xF0 -> exactly 12 shift_en cycles of 1; the second word's low nibble is never emitted; no third word_ready.
- Host drops word_valid for 5 cycles between words -> ccff_shift_en low for those cycles, no bit lost or duplicated, done still asserted.
- TIMEOUT=4, no word after start -> error=1 on the 5th cycle in FETCH, IO_ISOL_N=0, busy=0; a following start clears error and reloads successfully.
- Assert prog_reset_n=0 mid-SHIFT (bit 7 of 16) -> all outputs at reset values asynchronously (before the next prog_clk edge); a fresh start loads all 16 bits correctly.
- Chain model: a 16-bit shift register on ccff_head/ccff_shift_en, with its tail looped to ccff_tail -> after done, the model contents equal the streamed bitstream.
